// File: rtl/primus_pkg.sv
// Shared types and constants for the instruction-fetch slice of the core.
package primus_pkg;

  // Controller phase: boot loader owns the BRAM in LOAD, fetch owns it in RUN.
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // Canonical no-op (addi x0, x0, 0); shown on the output while nothing is valid.
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // One fetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam fetch_entry_t ENTRY_RESET = '{pc: 32'h0, inst: INST_NOP};

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-to-decode handshake: instruction word and its PC under valid/ready.
interface imem_fetch_ctrl_if;

  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  // The fetch side produces instructions, decode accepts them.
  modport master (output inst_valid, output inst, output inst_pc, input inst_ready);
  modport slave  (input inst_valid, input inst, input inst_pc, output inst_ready);

endinterface

// File: rtl/fetch_skid_buf.sv
// Output register plus a one-entry skid register for fetch_entry_t.
// The producer cannot be stalled once data is on its way, so it must only
// send when it knows a slot will be free; skid_full tells it when not to.
// Ordering is strict: output register, then skid, then incoming data.
module fetch_skid_buf
  import primus_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush,
  input  logic         in_valid,
  input  fetch_entry_t in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output fetch_entry_t out_data,
  output logic         skid_full
);

  logic         out_v_q, out_v_d;
  fetch_entry_t out_q,   out_d;
  logic         skid_v_q, skid_v_d;
  fetch_entry_t skid_q,   skid_d;
  logic         pop;

  assign pop       = out_v_q & out_ready;
  assign out_valid = out_v_q;
  assign out_data  = out_q;
  assign skid_full = skid_v_q;

  // Next contents of the output and skid slots.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    out_v_d  = out_v_q;
    out_d    = out_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;

    if (flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (!out_v_q || pop) begin
      // Output slot frees up: the oldest waiting entry moves into it.
      if (skid_v_q) begin
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_v_d = in_valid;
        if (in_valid) skid_d = in_data;
      end else begin
        out_v_d = in_valid;
        if (in_valid) out_d = in_data;
      end
    end else if (in_valid) begin
      // Output is stalled: park the arriving entry in the skid slot.
      skid_v_d = 1'b1;
      skid_d   = in_data;
    end
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      out_v_q  <= 1'b0;
      // NOTE: the data registers are reset too because the output data is visible after reset (NOP at pc 0).
      out_q    <= ENTRY_RESET;
      skid_v_q <= 1'b0;
      skid_q   <= '0;
    end else begin
      out_v_q  <= out_v_d;
      out_q    <= out_d;
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-BRAM sequencer. In LOAD the boot loader's write port is passed
// straight through to the BRAM; in RUN the controller owns the PC, issues one
// read per cycle and hands {pc, inst} to decode through fetch_skid_buf.
module imem_fetch_ctrl
  import primus_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              boot_done_i,
  input  logic              ld_we_i,
  input  logic [31:0]       ld_addr_i,
  input  logic [31:0]       ld_wdata_i,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  imem_fetch_ctrl_if.master dec,
  output logic              loading_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q;
  logic         inflight_q;
  logic [31:0]  inflight_pc_q;

  logic         run;
  logic         redirect_act;
  logic         issue;
  logic         skid_full;
  logic         out_valid;
  logic         ret_valid;
  fetch_entry_t ret_data;
  fetch_entry_t out_data;

  // Byte-offset bits and address bits above the BRAM index carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ld_addr_i[1:0], ld_addr_i[31:ADDR_W+2], redirect_pc_i[1:0]};

  assign run          = (state_q == RUN);
  assign redirect_act = run & redirect_i;

  // A read may only be issued if its data is guaranteed a slot when it returns:
  // the skid must be empty, and a read already in flight must not be headed
  // for the skid because the output is stalled this cycle.
  assign issue = run & ~redirect_i & ~skid_full
               & ~(inflight_q & out_valid & ~dec.inst_ready);

  // Phase sequencing: LOAD until the loader signals completion, then RUN until reset.
  always_comb begin
    state_d   = state_q;
    loading_o = 1'b0;
    case (state_q)
      LOAD: begin
        loading_o = 1'b1;
        if (boot_done_i) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = LOAD;
    endcase
  end

  // Phase register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= LOAD;
    else       state_q <= state_d;
  end

  // PC and in-flight read tracking; a redirect drops whatever read is returning.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (!run) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
    end else if (redirect_i) begin
      pc_q       <= {redirect_pc_i[31:2], 2'b00};
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 32'd4;
      end
    end
  end

  // BRAM port mux: loader pass-through in LOAD, read-only fetch in RUN.
  always_comb begin
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = pc_q[ADDR_W+1:2];
    mem_wdata_o = ld_wdata_i;
    if (!run) begin
      mem_we_o   = ld_we_i;
      mem_addr_o = ld_addr_i[ADDR_W+1:2];
    end else begin
      mem_re_o = issue;
    end
  end

  assign ret_valid = inflight_q & run;
  assign ret_data  = '{pc: inflight_pc_q, inst: mem_rdata_i};

  fetch_skid_buf u_skid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush     (redirect_act),
    .in_valid  (ret_valid),
    .in_data   (ret_data),
    .out_valid (out_valid),
    .out_ready (dec.inst_ready),
    .out_data  (out_data),
    .skid_full (skid_full)
  );

  assign dec.inst_valid = out_valid;
  assign dec.inst       = out_data.inst;
  assign dec.inst_pc    = out_data.pc;

endmodule
